// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, default loudness threshold,
// sample rate and the clap detector's FSM state encoding.
package audio_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SAMPLE_RATE = 48000;
    localparam int PEAK_WIDTH  = 10;
    localparam int RUN_WIDTH   = 8;

    localparam logic [DATA_WIDTH-1:0] DEFAULT_THRESHOLD = 32'h0800_0000;

    // Sample-pair sequencer: wait for data, pop it, rectify, evaluate.
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_POP  = 2'd1,
        ST_S1   = 2'd2,
        ST_S2   = 2'd3
    } state_t;

    // Run-length increment that sticks at all-ones instead of wrapping.
    function automatic logic [RUN_WIDTH-1:0] sat_inc(input logic [RUN_WIDTH-1:0] v);
        return (&v) ? v : v + RUN_WIDTH'(1);
    endfunction

endpackage

// File: rtl/clap_detector_if.sv
// ADC-side FIFO port of the audio controller: show-ahead head data, a
// registered "pair available" flag and a one-cycle pop strobe.
interface clap_detector_if #(
    parameter int DATA_WIDTH = audio_pkg::DATA_WIDTH
);
    logic                  audio_in_available;
    logic [DATA_WIDTH-1:0] left_channel_audio_in;
    logic [DATA_WIDTH-1:0] right_channel_audio_in;
    logic                  read_audio_in;

    // FIFO (controller) side.
    modport master (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in
    );

    // Consumer side.
    modport slave (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in
    );
endinterface

// File: rtl/abs_peak.sv
// Combinational rectifier: largest magnitude of two two's-complement samples.
// The most negative value has no positive counterpart and saturates to the
// largest positive value.
module abs_peak
    import audio_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic signed [WIDTH-1:0] left,
    input  logic signed [WIDTH-1:0] right,
    output logic        [WIDTH-1:0] peak
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
        if (!x[WIDTH-1])
            return x;
        else if (x[WIDTH-2:0] == '0)
            return MAX_POS;
        else
            return (~x) + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] mag_left;
    logic [WIDTH-1:0] mag_right;

    // Rectify both channels and keep the larger magnitude.
    always_comb begin
        mag_left  = sat_abs(left);
        mag_right = sat_abs(right);
        peak      = (mag_left > mag_right) ? mag_left : mag_right;
    end

endmodule

// File: rtl/clap_detector.sv
// Clap detector: drains stereo pairs from the audio controller's ADC FIFO,
// rectifies each pair, qualifies claps by run length with a hold-off, and
// reports single claps, double claps and a toggled lights state.
module clap_detector
    import audio_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] THRESHOLD     = DEFAULT_THRESHOLD,
    parameter int                    MIN_RUN       = 4,
    parameter int                    HOLDOFF       = SAMPLE_RATE / 4,
    parameter int                    DOUBLE_WINDOW = SAMPLE_RATE
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  enable,
    clap_detector_if.slave        audio,
    output logic                  clap_detected,
    output logic                  double_clap,
    output logic                  lights_on,
    output logic [RUN_WIDTH-1:0]  clap_count,
    output logic [PEAK_WIDTH-1:0] peak_level
);

    // DOUBLE_WINDOW exceeds HOLDOFF, so one width covers both counters.
    localparam int                   CNT_W      = $clog2(DOUBLE_WINDOW + 1);
    localparam logic [CNT_W-1:0]     HOLD_LOAD  = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0]     WIN_LOAD   = CNT_W'(DOUBLE_WINDOW);
    localparam logic [RUN_WIDTH-1:0] RUN_TARGET = RUN_WIDTH'(MIN_RUN);

    state_t state_q, state_d;
    logic   pop;

    logic signed [DATA_WIDTH-1:0] left_q, right_q;
    logic        [DATA_WIDTH-1:0] peak_abs, peak_q;

    logic [RUN_WIDTH-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]     win_q, win_d;
    logic [RUN_WIDTH-1:0] count_d;
    logic                 lights_d;
    logic                 loud, is_clap, is_double;

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn)
            state_q <= ST_WAIT;
        else
            state_q <= state_d;
    end

    // Next state and pop strobe. The two dead cycles after POP let the
    // controller's registered available flag reflect the pop.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_WAIT: if (audio.audio_in_available) state_d = ST_POP;
            ST_POP: begin
                pop     = 1'b1;
                state_d = ST_S1;
            end
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // Decoded straight from the state register, so reset drops it at once.
    assign audio.read_audio_in = pop;

    // Sample capture in POP and registered rectified peak in S1.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        // NOTE: data registers are reset as well, so a pair caught by reset is discarded rather than evaluated.
        if (!resetn) begin
            left_q  <= '0;
            right_q <= '0;
            peak_q  <= '0;
        end else begin
            if (state_q == ST_POP) begin
                left_q  <= audio.left_channel_audio_in;
                right_q <= audio.right_channel_audio_in;
            end
            if (state_q == ST_S1)
                peak_q <= peak_abs;
        end
    end

    abs_peak #(.WIDTH(DATA_WIDTH)) u_abs_peak (
        .left  (left_q),
        .right (right_q),
        .peak  (peak_abs)
    );

    // Per-pair evaluation in S2: run length, hold-off, double-clap window.
    always_comb begin
        loud      = (peak_q > THRESHOLD);
        run_inc   = loud ? sat_inc(run_q) : '0;
        is_clap   = 1'b0;
        is_double = 1'b0;
        run_d     = run_q;
        hold_d    = hold_q;
        win_d     = win_q;
        count_d   = clap_count;
        lights_d  = lights_on;
        if (state_q == ST_S2) begin
            if (!enable) begin
                run_d  = '0;
                hold_d = '0;
                win_d  = '0;
            end else begin
                is_clap = (run_inc == RUN_TARGET) && (hold_q == '0);
                run_d   = is_clap ? '0 : run_inc;
                hold_d  = is_clap ? HOLD_LOAD
                                  : ((hold_q != '0) ? hold_q - CNT_W'(1) : '0);
                win_d   = (win_q != '0) ? win_q - CNT_W'(1) : '0;
                if (is_clap) begin
                    count_d = clap_count + RUN_WIDTH'(1);
                    if (win_q != '0) begin
                        // Second clap inside the window; closing it stops triple chaining.
                        is_double = 1'b1;
                        lights_d  = ~lights_on;
                        win_d     = '0;
                    end else begin
                        win_d = WIN_LOAD;
                    end
                end
            end
        end
    end

    // Counter state, registered pulses and the LED meter level.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_q         <= '0;
            hold_q        <= '0;
            win_q         <= '0;
            clap_count    <= '0;
            lights_on     <= 1'b0;
            clap_detected <= 1'b0;
            double_clap   <= 1'b0;
            peak_level    <= '0;
        end else begin
            run_q         <= run_d;
            hold_q        <= hold_d;
            win_q         <= win_d;
            clap_count    <= count_d;
            lights_on     <= lights_d;
            clap_detected <= is_clap;
            double_clap   <= is_double;
            if (state_q == ST_S2)
                peak_level <= peak_q[DATA_WIDTH-2 -: PEAK_WIDTH];
        end
    end

endmodule

// File: tb/tb_clap_detector.sv
// Self-checking bench for clap_detector: a FIFO model feeds pairs, a
// pair-index based reference model predicts outputs, and one compare process
// checks the DUT against it on every falling clock edge.
module tb_clap_detector;
    import audio_pkg::*;

    localparam int          MIN_RUN       = 4;
    localparam int          HOLDOFF       = 16;
    localparam int          DOUBLE_WINDOW = 40;
    localparam logic [31:0] THRESHOLD     = DEFAULT_THRESHOLD;
    localparam logic [31:0] LOUD          = 32'h4000_0000;
    localparam logic [31:0] QUIET_P       = 32'h0000_0100;
    localparam logic [31:0] QUIET_N       = 32'hFFFF_FF00;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b1;
    logic       enable   = 1'b0;
    logic       clap_detected, double_clap, lights_on;
    logic [7:0] clap_count;
    logic [9:0] peak_level;

    clap_detector_if aif ();

    clap_detector #(
        .THRESHOLD     (THRESHOLD),
        .MIN_RUN       (MIN_RUN),
        .HOLDOFF       (HOLDOFF),
        .DOUBLE_WINDOW (DOUBLE_WINDOW)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .enable        (enable),
        .audio         (aif),
        .clap_detected (clap_detected),
        .double_clap   (double_clap),
        .lights_on     (lights_on),
        .clap_count    (clap_count),
        .peak_level    (peak_level)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    typedef struct {
        int    eval_cycle;
        pair_t p;
    } pend_t;

    pair_t fifo_q[$];
    pend_t pend_q[$];
    int    pop_cycles[$];
    int    clap_cycles[$];
    bit    pop_pending = 1'b0;
    int    cycle = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_claps = 0;
    int    n_doubles = 0;
    logic  prev_read = 1'b0;

    // Reference model: pair index of the last clap and of the clap that
    // opened the double window (-1 = none), plus the current loud run.
    int         m_run, m_last_clap, m_open, m_idx;
    logic [7:0] e_count;
    logic       e_lights, e_clap, e_double;
    logic [9:0] e_peak;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic longint mag(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_last_clap = -1; m_open = -1; m_idx = 0;
        e_count = 0; e_lights = 0; e_peak = 0; e_clap = 0; e_double = 0;
        pend_q.delete();
    endtask

    task automatic model_eval(input pair_t p, input bit en);
        longint      pk;
        logic [31:0] pk32;
        pk   = (mag(p.l) > mag(p.r)) ? mag(p.l) : mag(p.r);
        pk32 = pk[31:0];
        e_peak = pk32[30:21];
        if (!en) begin
            m_run = 0; m_last_clap = -1; m_open = -1;
        end else begin
            if (pk > longint'({32'b0, THRESHOLD})) m_run = (m_run < 255) ? m_run + 1 : 255;
            else m_run = 0;
            if (m_run == MIN_RUN && !(m_last_clap >= 0 && m_idx - m_last_clap <= HOLDOFF)) begin
                e_clap      = 1;
                e_count     = e_count + 8'd1;
                m_run       = 0;
                m_last_clap = m_idx;
                if (m_open >= 0 && m_idx - m_open <= DOUBLE_WINDOW) begin
                    e_double = 1;
                    e_lights = ~e_lights;
                    m_open   = -1;
                end else begin
                    m_open = m_idx;
                end
            end
        end
        m_idx++;
    endtask

    // Controller FIFO model: pops after the edge that ends a POP cycle and
    // presents a registered available flag with show-ahead head data.
    initial begin
        aif.audio_in_available     = 1'b0;
        aif.left_channel_audio_in  = '0;
        aif.right_channel_audio_in = '0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (pop_pending) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pop_pending = 1'b0;
            end
            aif.audio_in_available = (fifo_q.size() > 0);
            if (fifo_q.size() > 0) begin
                aif.left_channel_audio_in  = fifo_q[0].l;
                aif.right_channel_audio_in = fifo_q[0].r;
            end
        end
    end

    // Compare process: checks every output on each falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge CLOCK_50);
            cycle++;
            if (!resetn) begin
                check("rst_read",   aif.read_audio_in, 0);
                check("rst_clap",   clap_detected, 0);
                check("rst_double", double_clap, 0);
                check("rst_lights", lights_on, 0);
                check("rst_count",  clap_count, 0);
                check("rst_peak",   peak_level, 0);
                model_reset();
                prev_read = 1'b0;
            end else begin
                check("clap_detected", clap_detected, e_clap);
                check("double_clap",   double_clap, e_double);
                check("lights_on",     lights_on, e_lights);
                check("clap_count",    clap_count, e_count);
                check("peak_level",    peak_level, e_peak);
                check("pop_one_cycle", prev_read & aif.read_audio_in, 0);
                if (clap_detected === 1'b1) begin
                    n_claps++;
                    clap_cycles.push_back(cycle);
                end
                if (double_clap === 1'b1) n_doubles++;
                e_clap   = 0;
                e_double = 0;
                if (pend_q.size() > 0 && pend_q[0].eval_cycle == cycle) begin
                    model_eval(pend_q[0].p, enable);
                    void'(pend_q.pop_front());
                end
                if (aif.read_audio_in === 1'b1) begin
                    check("pop_nonempty", fifo_q.size() > 0, 1);
                    if (fifo_q.size() > 0) begin
                        pend_t e;
                        e.eval_cycle = cycle + 2;
                        e.p          = fifo_q[0];
                        pend_q.push_back(e);
                        pop_pending = 1'b1;
                    end
                    pop_cycles.push_back(cycle);
                end
                prev_read = aif.read_audio_in;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r, input int n);
        pair_t p;
        p.l = l;
        p.r = r;
        repeat (n) fifo_q.push_back(p);
    endtask

    task automatic flush();
        int budget = 5000;
        while ((fifo_q.size() != 0 || pend_q.size() != 0 || pop_pending) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check("flush_timeout", 0, 1);
        tick(2);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    function automatic logic [31:0] rand_sample(input bit loud);
        logic [31:0] v;
        if (loud) begin
            case ($urandom_range(0, 4))
                0:       v = 32'h8000_0000;
                1:       v = 32'h7FFF_FFFF;
                2:       v = THRESHOLD + 32'd1;
                3:       v = -(THRESHOLD + 32'd1);
                default: v = $urandom_range(32'h0800_0001, 32'h7FFF_FFFF);
            endcase
        end else begin
            case ($urandom_range(0, 3))
                0:       v = THRESHOLD;
                1:       v = -THRESHOLD;
                2:       v = $urandom_range(0, 32'h07FF_FFFF);
                default: v = -($urandom_range(0, 32'h07FF_FFFF));
            endcase
        end
        return v;
    endfunction

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int base_claps, base_doubles, budget;
        #1 resetn = 1'b0;
        tick(3);
        check("reset_count",  clap_count, 0);
        check("reset_lights", lights_on, 0);
        check("reset_read",   aif.read_audio_in, 0);
        resetn = 1'b1;
        enable = 1'b1;
        tick(2);

        // Drain of quiet pairs: 10 pops, 4 cycles apart, nothing detected.
        pop_cycles.delete();
        push(QUIET_P, QUIET_N, 10);
        flush();
        check("drain_pops", pop_cycles.size(), 10);
        for (int i = 1; i < pop_cycles.size(); i++)
            check("drain_gap", pop_cycles[i] - pop_cycles[i-1], 4);
        check("drain_no_clap", n_claps, 0);
        check("drain_peak", peak_level, 10'h000);

        // Single clap three cycles after the 4th loud pop.
        pop_cycles.delete();
        clap_cycles.delete();
        push(LOUD, QUIET_P, 4);
        push(QUIET_P, QUIET_N, 4);
        flush();
        check("single_claps", n_claps, 1);
        check("single_count", clap_count, 8'd1);
        check("single_latency",
              (clap_cycles.size() > 0 && pop_cycles.size() > 3) ? clap_cycles[0] - pop_cycles[3] : -1, 3);

        // Short burst of 3 loud pairs after the hold-off has expired.
        push(QUIET_P, QUIET_N, 20);
        push(QUIET_N, LOUD, 3);
        push(QUIET_P, QUIET_N, 3);
        flush();
        check("short_no_clap", n_claps, 1);

        // Hold-off: 8 loud pairs give one clap; a second burst is a double.
        do_reset();
        base_claps = n_claps;
        base_doubles = n_doubles;
        push(LOUD, LOUD, 8);
        flush();
        check("holdoff_one_clap", n_claps - base_claps, 1);
        push(QUIET_P, QUIET_N, 20);
        push(LOUD, QUIET_N, 4);
        push(QUIET_P, QUIET_N, 2);
        flush();
        check("double_pulse", n_doubles - base_doubles, 1);
        check("double_lights", lights_on, 1);
        check("double_count", clap_count, 8'd2);

        // Window expiry: claps DOUBLE_WINDOW+5 pairs apart are two singles.
        base_claps = n_claps;
        base_doubles = n_doubles;
        push(QUIET_P, QUIET_N, 20);
        push(LOUD, QUIET_P, 4);
        push(QUIET_P, QUIET_N, DOUBLE_WINDOW + 1);
        push(LOUD, QUIET_P, 4);
        push(QUIET_P, QUIET_N, 2);
        flush();
        check("expiry_claps", n_claps - base_claps, 2);
        check("expiry_no_double", n_doubles - base_doubles, 0);
        check("expiry_lights", lights_on, 1);
        check("expiry_count", clap_count, 8'd4);

        // Saturated rectification of the most negative sample.
        push(QUIET_P, 32'h8000_0000, 1);
        flush();
        check("sat_peak", peak_level, 10'h3FF);

        // Detection disabled: pops continue, no pulses, state retained.
        enable = 1'b0;
        base_claps = n_claps;
        pop_cycles.delete();
        push(LOUD, LOUD, 4);
        flush();
        check("disabled_pops", pop_cycles.size(), 4);
        check("disabled_no_clap", n_claps - base_claps, 0);
        check("disabled_count", clap_count, 8'd4);
        check("disabled_lights", lights_on, 1);
        enable = 1'b1;

        // Randomized bursts with gaps and occasional enable changes.
        for (int k = 0; k < 80; k++) begin
            bit loud_burst;
            int len;
            loud_burst = ($urandom_range(0, 1) == 1);
            len = loud_burst ? $urandom_range(1, 6) : $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 1) == 1)
                    push(rand_sample(loud_burst), rand_sample($urandom_range(0, 1) == 1), 1);
                else
                    push(rand_sample($urandom_range(0, 1) == 1), rand_sample(loud_burst), 1);
            end
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 10));
            if ($urandom_range(0, 19) == 0) enable = ~enable;
        end
        flush();
        enable = 1'b1;

        // Give the outputs a known nonzero state, then reset during POP.
        push(LOUD, LOUD, 4);
        push(QUIET_P, QUIET_N, 2);
        flush();
        push(QUIET_P, QUIET_N, 2);
        budget = 50;
        while (aif.read_audio_in !== 1'b1 && budget > 0) begin
            tick(1);
            budget--;
        end
        check("pop_seen_before_reset", aif.read_audio_in, 1);
        #1 resetn = 1'b0;
        #1;
        check("midpop_read",   aif.read_audio_in, 0);
        check("midpop_count",  clap_count, 0);
        check("midpop_lights", lights_on, 0);
        check("midpop_peak",   peak_level, 0);
        check("midpop_pulses", {clap_detected, double_clap}, 2'b00);
        tick(2);
        resetn = 1'b1;
        tick(1);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
